// File: rtl/code_event_logger.sv
// Code event logger: detects changes on an 8-bit code stream and queues
// {code, stamp} events in a show-ahead FIFO with overflow and 0xFF match count.
//
// Ports:
//   clk, rstN            clock, asynchronous active-low reset
//   code_in, enable      sampled code stream and sampling enable
//   clear                synchronous clear of FIFO, flags, counters
//   ev_valid/ev_ready    head-of-FIFO handshake
//   ev_code, ev_stamp    head event contents (zero when empty)
//   full, overflow       FIFO full, sticky drop flag
//   match_cnt            saturating count of pushed 0xFF events
module code_event_logger #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [7:0] code_in,
    input  logic       enable,
    input  logic       clear,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic [7:0] ev_stamp,
    output logic       full,
    output logic       overflow,
    output logic [7:0] match_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    prev_q, prev_d;
    logic [7:0]    stamp_q, stamp_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_code_q, pend_code_d;
    logic [7:0]    pend_stamp_q, pend_stamp_d;
    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    match_q, match_d;

    logic          pop;
    logic          det;
    logic          push_ok;
    logic [15:0]   head;

    assign ev_valid  = (cnt_q != '0);
    assign full      = (cnt_q == CW'(DEPTH));
    assign head      = mem_q[rd_q];
    assign ev_code   = ev_valid ? head[15:8] : 8'h00;
    assign ev_stamp  = ev_valid ? head[7:0] : 8'h00;
    assign overflow  = ovf_q;
    assign match_cnt = match_q;

    assign pop     = ev_valid & ev_ready;
    assign det     = enable & ~clear & (code_in != prev_q);
    // Detected events are staged one cycle before entering the FIFO,
    // so a pop in the staging cycle frees room for a full FIFO.
    assign push_ok = pend_q & (~full | pop);

    always_comb begin
        prev_d       = prev_q;
        stamp_d      = stamp_q;
        pend_d       = 1'b0;
        pend_code_d  = code_in;
        pend_stamp_d = stamp_q;
        mem_d        = mem_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        match_d      = match_q;

        if (clear) begin
            prev_d  = code_in;
            stamp_d = 8'h00;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            match_d = 8'h00;
        end else begin
            if (enable) begin
                prev_d = code_in;
                if (det) begin
                    stamp_d = 8'h01;
                end else if (stamp_q != 8'hFF) begin
                    stamp_d = stamp_q + 8'd1;
                end
            end
            pend_d = det;

            if (pop) begin
                rd_d = rd_q + AW'(1);
            end
            if (push_ok) begin
                mem_d[wr_q] = {pend_code_q, pend_stamp_q};
                wr_d        = wr_q + AW'(1);
                if (pend_code_q == 8'hFF && match_q != 8'hFF) begin
                    match_d = match_q + 8'd1;
                end
            end
            if (pend_q && !push_ok) begin
                ovf_d = 1'b1;
            end

            if (push_ok && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop && !push_ok) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            prev_q       <= 8'h00;
            stamp_q      <= 8'h00;
            pend_q       <= 1'b0;
            pend_code_q  <= 8'h00;
            pend_stamp_q <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            match_q      <= 8'h00;
        end else begin
            prev_q       <= prev_d;
            stamp_q      <= stamp_d;
            pend_q       <= pend_d;
            pend_code_q  <= pend_code_d;
            pend_stamp_q <= pend_stamp_d;
            mem_q        <= mem_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            match_q      <= match_d;
        end
    end

endmodule

// File: tb/tb_code_event_logger.sv
// Testbench for code_event_logger: queue-based scoreboard of expected
// FIFO contents plus directed checks of the logger's key scenarios.
module tb_code_event_logger;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [7:0] code_in = 8'h00;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [7:0] ev_code;
    logic [7:0] ev_stamp;
    logic       full;
    logic       overflow;
    logic [7:0] match_cnt;

    code_event_logger #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .code_in   (code_in),
        .enable    (enable),
        .clear     (clear),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_stamp  (ev_stamp),
        .full      (full),
        .overflow  (overflow),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] sb_q [$];
    logic [7:0]  m_prev, m_stamp, m_pcode, m_pstamp, m_match;
    logic        m_pend, m_ovf;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_prev   = 8'h00;
        m_stamp  = 8'h00;
        m_pcode  = 8'h00;
        m_pstamp = 8'h00;
        m_match  = 8'h00;
        m_pend   = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] c, input logic e,
                              input logic r, input logic cl);
        logic ev;
        if (cl) begin
            sb_q.delete();
            m_pend  = 1'b0;
            m_ovf   = 1'b0;
            m_match = 8'h00;
            m_stamp = 8'h00;
            m_prev  = c;
        end else begin
            if (sb_q.size() != 0 && r) void'(sb_q.pop_front());
            if (m_pend) begin
                if (sb_q.size() < DEPTH) begin
                    sb_q.push_back({m_pcode, m_pstamp});
                    if (m_pcode == 8'hFF && m_match != 8'hFF) m_match++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            ev = e && (c != m_prev);
            m_pend = ev;
            if (ev) begin
                m_pcode  = c;
                m_pstamp = m_stamp;
                m_stamp  = 8'h01;
            end else if (e && m_stamp != 8'hFF) begin
                m_stamp++;
            end
            if (e) m_prev = c;
        end
    endtask

    task automatic compare_all();
        logic [15:0] h;
        h = (sb_q.size() != 0) ? sb_q[0] : 16'h0000;
        check("ev_valid", ev_valid, sb_q.size() != 0);
        check("ev_code", ev_code, h[15:8]);
        check("ev_stamp", ev_stamp, h[7:0]);
        check("full", full, sb_q.size() == DEPTH);
        check("overflow", overflow, m_ovf);
        check("match_cnt", match_cnt, m_match);
    endtask

    task automatic cycle(input logic [7:0] c, input logic e,
                         input logic r, input logic cl);
        code_in  = c;
        enable   = e;
        ev_ready = r;
        clear    = cl;
        @(posedge clk);
        model_edge(c, e, r, cl);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rstN     = 1'b0;
        code_in  = 8'h00;
        enable   = 1'b0;
        ev_ready = 1'b0;
        clear    = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        compare_all();
        rstN = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Two events from a 0x30 run followed by 0x50
        cycle(8'h30, 1, 0, 0);
        check("s1_lat", ev_valid, 1'b0);
        cycle(8'h30, 1, 0, 0);
        check("s1_code0", ev_code, 8'h30);
        check("s1_stamp0", ev_stamp, 8'h00);
        cycle(8'h30, 1, 0, 0);
        cycle(8'h50, 1, 0, 0);
        cycle(8'h50, 1, 0, 0);
        cycle(8'h50, 1, 1, 0);
        check("s1_code1", ev_code, 8'h50);
        check("s1_stamp1", ev_stamp, 8'h03);
        cycle(8'h50, 1, 1, 0);

        // Fill with ready low, fifth event dropped, drain in order
        cycle(8'h00, 1, 0, 1);
        for (int i = 1; i <= 5; i++) cycle(8'(i), 1, 0, 0);
        cycle(8'h05, 1, 0, 0);
        check("s2_full", full, 1'b1);
        check("s2_ovf", overflow, 1'b1);
        check("s2_head", ev_code, 8'h01);
        for (int i = 0; i < 5; i++) cycle(8'h05, 1, 1, 0);
        check("s2_empty", ev_valid, 1'b0);
        check("s2_ovf_sticky", overflow, 1'b1);

        // Push into a full FIFO while popping
        cycle(8'h00, 1, 0, 1);
        for (int i = 1; i <= 4; i++) cycle(8'(i), 1, 0, 0);
        cycle(8'h04, 1, 0, 0);
        cycle(8'h09, 1, 0, 0);
        cycle(8'h09, 1, 1, 0);
        check("s3_full", full, 1'b1);
        check("s3_ovf", overflow, 1'b0);
        check("s3_head", ev_code, 8'h02);

        // Match counting and saturation
        cycle(8'h54, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(8'hFF, 1, 1, 0);
            cycle(8'h54, 1, 1, 0);
        end
        check("s4_m3", match_cnt, 8'd3);
        for (int i = 0; i < 300; i++) begin
            cycle(8'hFF, 1, 1, 0);
            cycle(8'h54, 1, 1, 0);
        end
        cycle(8'h54, 1, 1, 0);
        check("s4_msat", match_cnt, 8'hFF);

        // Stamp saturation, then no events while disabled
        cycle(8'h11, 1, 0, 1);
        for (int i = 0; i < 300; i++) cycle(8'h11, 1, 0, 0);
        cycle(8'h22, 1, 0, 0);
        cycle(8'h22, 1, 0, 0);
        check("s5_stamp", ev_stamp, 8'hFF);
        cycle(8'h33, 0, 0, 0);
        cycle(8'h44, 0, 0, 0);
        cycle(8'h55, 0, 0, 0);
        check("s5_noev", ev_code, 8'h22);
        cycle(8'h22, 1, 0, 0);
        cycle(8'h22, 1, 0, 0);
        check("s5_noev2", full, 1'b0);

        // Clear with two queued events and overflow set
        cycle(8'h00, 1, 0, 1);
        for (int i = 1; i <= 5; i++) cycle(8'(i), 1, 0, 0);
        cycle(8'h05, 1, 0, 0);
        cycle(8'h05, 1, 1, 0);
        cycle(8'h05, 1, 1, 0);
        check("s6_ovf_pre", overflow, 1'b1);
        cycle(8'h77, 1, 0, 1);
        check("s6_valid", ev_valid, 1'b0);
        check("s6_ovf", overflow, 1'b0);
        check("s6_match", match_cnt, 8'h00);
        cycle(8'h77, 1, 0, 0);
        cycle(8'h77, 1, 0, 0);
        check("s6_noev", ev_valid, 1'b0);

        // Reset in the middle of traffic
        cycle(8'hA0, 1, 0, 0);
        cycle(8'hA1, 1, 0, 0);
        cycle(8'hA2, 1, 0, 0);
        do_reset();
        check("rst_valid", ev_valid, 1'b0);
        cycle(8'h00, 1, 0, 0);
        cycle(8'h00, 1, 0, 0);
        check("rst_noev", ev_valid, 1'b0);
        cycle(8'hC3, 1, 0, 0);
        cycle(8'hC3, 1, 1, 0);
        cycle(8'hC3, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
